// File: rtl/writeback_ctrl.sv
// writeback_ctrl: sequences one register-file writeback per request.
// A request is captured in IDLE, waits for its source to become valid
// (fixed memory latency or mult/div completion), then issues a single-cycle
// write. Illegal source codes produce a single-cycle error/ack and no write.
// All outputs are registered and depend only on the state being entered.
module writeback_ctrl #(
    parameter int MEM_WAIT = 2,
    parameter int SEL_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_req,
    input  logic [SEL_W-1:0] wb_src,
    input  logic [1:0]       wb_dst,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic             md_busy,
    input  logic             md_done,
    output logic [SEL_W-1:0] memtoreg_sel,
    output logic [4:0]       write_reg,
    output logic             reg_write,
    output logic             wb_busy,
    output logic             wb_ack,
    output logic             src_err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_MEM = 3'd1;
    localparam logic [2:0] S_WAIT_MD  = 3'd2;
    localparam logic [2:0] S_WRITE    = 3'd3;
    localparam logic [2:0] S_ERR      = 3'd4;

    localparam logic [SEL_W-1:0] SRC_LOAD = SEL_W'(1);
    localparam logic [SEL_W-1:0] SRC_HI   = SEL_W'(2);
    localparam logic [SEL_W-1:0] SRC_LO   = SEL_W'(3);
    localparam logic [SEL_W-1:0] SRC_MAX  = SEL_W'(10);

    // The counter is loaded with MEM_WAIT-1 so WAIT_MEM lasts MEM_WAIT cycles.
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [4:0]       idx_q, idx_d;
    logic [4:0]       dst_idx;

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [4:0]       wr_q, wr_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    // Resolve the destination register index from the instruction fields.
    always_comb begin
        dst_idx = rt;
        case (wb_dst)
            2'd0:    dst_idx = rt;
            2'd1:    dst_idx = rd;
            2'd2:    dst_idx = 5'd31;
            default: dst_idx = 5'd29;
        endcase
    end

    // Next-state, capture and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (wb_req) begin
                    src_d = wb_src;
                    idx_d = dst_idx;
                    if (wb_src > SRC_MAX) begin
                        state_d = S_ERR;
                    end else if (wb_src == SRC_LOAD) begin
                        state_d = S_WAIT_MEM;
                        cnt_d   = WAIT_INIT;
                    end else if ((wb_src == SRC_HI || wb_src == SRC_LO) && md_busy) begin
                        state_d = S_WAIT_MD;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WAIT_MD: begin
                // No timeout: the mult/div unit is trusted to finish.
                if (md_done || !md_busy) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs computed from the state about to be entered.
    always_comb begin
        sel_d  = '0;
        wr_d   = wr_q;
        we_d   = 1'b0;
        busy_d = (state_d != S_IDLE);
        ack_d  = (state_d == S_WRITE) || (state_d == S_ERR);
        err_d  = (state_d == S_ERR);
        if (state_d == S_WRITE) begin
            sel_d = src_d;
            wr_d  = idx_d;
            // Writes to $0 are acknowledged but never enabled.
            we_d  = (idx_d != 5'd0);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            src_q   <= '0;
            idx_q   <= 5'd0;
            sel_q   <= '0;
            wr_q    <= 5'd0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign memtoreg_sel = sel_q;
    assign write_reg    = wr_q;
    assign reg_write    = we_q;
    assign wb_busy      = busy_q;
    assign wb_ack       = ack_q;
    assign src_err      = err_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Testbench for writeback_ctrl: directed scenarios plus a randomized
// transaction-level reference model (latency and result per request).
module tb_writeback_ctrl;

    localparam int MEM_WAIT = 2;
    localparam int SEL_W    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             wb_req;
    logic [SEL_W-1:0] wb_src;
    logic [1:0]       wb_dst;
    logic [4:0]       rt, rd;
    logic             md_busy, md_done;
    logic [SEL_W-1:0] memtoreg_sel;
    logic [4:0]       write_reg;
    logic             reg_write, wb_busy, wb_ack, src_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] last_wr;   // model of the held write_reg value

    always #5 clk = ~clk;

    writeback_ctrl #(.MEM_WAIT(MEM_WAIT), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset), .wb_req(wb_req), .wb_src(wb_src),
        .wb_dst(wb_dst), .rt(rt), .rd(rd), .md_busy(md_busy),
        .md_done(md_done), .memtoreg_sel(memtoreg_sel), .write_reg(write_reg),
        .reg_write(reg_write), .wb_busy(wb_busy), .wb_ack(wb_ack),
        .src_err(src_err)
    );

    // {busy, ack, err, we, sel, write_reg}
    wire [12:0] obs = {wb_busy, wb_ack, src_err, reg_write, memtoreg_sel, write_reg};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] dst_of(input logic [1:0] d, input logic [4:0] t, input logic [4:0] r);
        return (d == 2'd0) ? t : (d == 2'd1) ? r : (d == 2'd2) ? 5'd31 : 5'd29;
    endfunction

    task automatic test_reset;
        reset = 1'b1; wb_req = 1'b0; wb_src = '0; wb_dst = 2'd0;
        rt = 5'd0; rd = 5'd0; md_busy = 1'b0; md_done = 1'b0;
        tick(); tick();
        n_checks++;
        if (obs !== 13'd0) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs, 13'd0);
        end
        reset = 1'b0;
        last_wr = 5'd0;
        tick();
    endtask

    task automatic test_direct;
        wb_req = 1'b1; wb_src = 4'd0; wb_dst = 2'd1; rd = 5'd5; rt = 5'd7;
        tick(); wb_req = 1'b0;
        n_checks++;
        if (obs !== {4'b1101, 4'd0, 5'd5}) begin
            n_fail++; $display("FAIL direct_write: got %h expected %h", obs, {4'b1101, 4'd0, 5'd5});
        end
        tick();
        n_checks++;
        if (obs !== {4'b0000, 4'd0, 5'd5}) begin
            n_fail++; $display("FAIL direct_idle: got %h expected %h", obs, {4'b0000, 4'd0, 5'd5});
        end
        last_wr = 5'd5;
        $display("txn direct src=0 rd=5 done");
    endtask

    task automatic test_loadsize;
        wb_req = 1'b1; wb_src = 4'd1; wb_dst = 2'd0; rt = 5'd9; rd = 5'd2;
        md_busy = 1'b1; md_done = 1'b1;   // must be ignored for LoadSize
        tick(); wb_req = 1'b0;
        for (int i = 0; i < MEM_WAIT; i++) begin
            n_checks++;
            if (obs !== {4'b1000, 4'd0, last_wr}) begin
                n_fail++; $display("FAIL load_wait[%0d]: got %h expected %h", i, obs, {4'b1000, 4'd0, last_wr});
            end
            tick();
        end
        n_checks++;
        if (obs !== {4'b1101, 4'd1, 5'd9}) begin
            n_fail++; $display("FAIL load_write: got %h expected %h", obs, {4'b1101, 4'd1, 5'd9});
        end
        md_busy = 1'b0; md_done = 1'b0;
        tick();
        last_wr = 5'd9;
        n_checks++;
        if (obs !== {4'b0000, 4'd0, 5'd9}) begin
            n_fail++; $display("FAIL load_idle: got %h expected %h", obs, {4'b0000, 4'd0, 5'd9});
        end
        $display("txn loadsize rt=9 done");
    endtask

    task automatic test_md_wait;
        md_busy = 1'b1;
        wb_req = 1'b1; wb_src = 4'd2; wb_dst = 2'd1; rd = 5'd17;
        tick(); wb_req = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            n_checks++;
            if (obs !== {4'b1000, 4'd0, last_wr}) begin
                n_fail++; $display("FAIL md_wait[%0d]: got %h expected %h", i, obs, {4'b1000, 4'd0, last_wr});
            end
            wb_req = (i == 5);
            if (i == 5) begin wb_src = 4'd0; rd = 5'd3; end
            md_done = (i == 20);
            tick();
        end
        md_done = 1'b0; md_busy = 1'b0; wb_req = 1'b0;
        n_checks++;
        if (obs !== {4'b1101, 4'd2, 5'd17}) begin
            n_fail++; $display("FAIL md_write: got %h expected %h", obs, {4'b1101, 4'd2, 5'd17});
        end
        last_wr = 5'd17;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== {4'b0000, 4'd0, 5'd17}) begin
                n_fail++; $display("FAIL md_no_queue[%0d]: got %h expected %h", i, obs, {4'b0000, 4'd0, 5'd17});
            end
        end
        $display("txn hi wait=20 done");
    endtask

    task automatic test_const_and_zero;
        wb_req = 1'b1; wb_src = 4'd8; wb_dst = 2'd2;
        tick(); wb_req = 1'b0;
        n_checks++;
        if (obs !== {4'b1101, 4'd8, 5'd31}) begin
            n_fail++; $display("FAIL const_ra: got %h expected %h", obs, {4'b1101, 4'd8, 5'd31});
        end
        tick();
        wb_req = 1'b1; wb_src = 4'd10; wb_dst = 2'd3;
        tick(); wb_req = 1'b0;
        n_checks++;
        if (obs !== {4'b1101, 4'd10, 5'd29}) begin
            n_fail++; $display("FAIL b_sp: got %h expected %h", obs, {4'b1101, 4'd10, 5'd29});
        end
        tick();
        wb_req = 1'b1; wb_src = 4'd0; wb_dst = 2'd0; rt = 5'd0;
        tick(); wb_req = 1'b0;
        n_checks++;
        if (obs !== {4'b1100, 4'd0, 5'd0}) begin
            n_fail++; $display("FAIL zero_reg: got %h expected %h", obs, {4'b1100, 4'd0, 5'd0});
        end
        last_wr = 5'd0;
        tick();
        $display("txn const/sp/zero done");
    endtask

    task automatic test_illegal;
        wb_req = 1'b1; wb_src = 4'd12; wb_dst = 2'd1; rd = 5'd14;
        tick(); wb_req = 1'b0;
        n_checks++;
        if (obs !== {4'b1110, 4'd0, last_wr}) begin
            n_fail++; $display("FAIL illegal_err: got %h expected %h", obs, {4'b1110, 4'd0, last_wr});
        end
        tick();
        n_checks++;
        if (obs !== {4'b0000, 4'd0, last_wr}) begin
            n_fail++; $display("FAIL illegal_idle: got %h expected %h", obs, {4'b0000, 4'd0, last_wr});
        end
        $display("txn illegal src=12 done");
    endtask

    task automatic test_back_to_back;
        wb_req = 1'b1; wb_src = 4'd9; wb_dst = 2'd1; rd = 5'd6;
        tick();
        wb_src = 4'd10; rd = 5'd11;    // request held through the WRITE cycle
        n_checks++;
        if (obs !== {4'b1101, 4'd9, 5'd6}) begin
            n_fail++; $display("FAIL b2b_first: got %h expected %h", obs, {4'b1101, 4'd9, 5'd6});
        end
        tick();
        n_checks++;
        if (obs !== {4'b0000, 4'd0, 5'd6}) begin
            n_fail++; $display("FAIL b2b_idle: got %h expected %h", obs, {4'b0000, 4'd0, 5'd6});
        end
        tick(); wb_req = 1'b0;
        n_checks++;
        if (obs !== {4'b1101, 4'd10, 5'd11}) begin
            n_fail++; $display("FAIL b2b_second: got %h expected %h", obs, {4'b1101, 4'd10, 5'd11});
        end
        last_wr = 5'd11;
        tick();
        $display("txn back_to_back done");
    endtask

    task automatic test_reset_midwait;
        wb_req = 1'b1; wb_src = 4'd1; wb_dst = 2'd1; rd = 5'd21;
        tick(); wb_req = 1'b0;
        tick();                       // second WAIT_MEM cycle
        reset = 1'b1;
        tick(); reset = 1'b0;
        last_wr = 5'd0;
        for (int i = 0; i < MEM_WAIT + 3; i++) begin
            n_checks++;
            if (obs !== 13'd0) begin
                n_fail++; $display("FAIL rst_mem[%0d]: got %h expected %h", i, obs, 13'd0);
            end
            tick();
        end
        md_busy = 1'b1;
        wb_req = 1'b1; wb_src = 4'd3; wb_dst = 2'd2;
        tick(); wb_req = 1'b0;
        reset = 1'b1;
        tick(); reset = 1'b0; md_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs !== 13'd0) begin
                n_fail++; $display("FAIL rst_md[%0d]: got %h expected %h", i, obs, 13'd0);
            end
            tick();
        end
        reset = 1'b1; wb_req = 1'b1; wb_src = 4'd0; wb_dst = 2'd2;
        tick(); reset = 1'b0; wb_req = 1'b0;
        n_checks++;
        if (obs !== 13'd0) begin
            n_fail++; $display("FAIL rst_priority: got %h expected %h", obs, 13'd0);
        end
        tick();
        $display("txn reset mid-wait done");
    endtask

    task automatic test_random;
        for (int t = 0; t < 200; t++) begin
            logic [3:0]  s;
            logic [1:0]  d;
            logic [4:0]  trt, trd, idx;
            logic        hilo, mdb, drop;
            int          dly, lat;
            logic [12:0] exp_fin;
            s    = 4'($urandom_range(0, 15));
            d    = 2'($urandom_range(0, 3));
            trt  = 5'($urandom);
            trd  = 5'($urandom);
            hilo = (s == 4'd2) || (s == 4'd3);
            mdb  = 1'($urandom);
            drop = 1'($urandom);
            dly  = $urandom_range(1, 12);
            idx  = dst_of(d, trt, trd);
            if (s > 4'd10)          lat = 1;
            else if (s == 4'd1)     lat = MEM_WAIT + 1;
            else if (hilo && mdb)   lat = dly + 1;
            else                    lat = 1;
            if (s > 4'd10) exp_fin = {4'b1110, 4'd0, last_wr};
            else           exp_fin = {3'b110, (idx != 5'd0), s, idx};
            wb_req = 1'b1; wb_src = s; wb_dst = d; rt = trt; rd = trd;
            md_busy = hilo ? mdb : 1'($urandom);
            md_done = hilo ? 1'b0 : 1'($urandom);
            tick();
            for (int c = 1; c < lat; c++) begin
                n_checks++;
                if (obs !== {4'b1000, 4'd0, last_wr}) begin
                    n_fail++; $display("FAIL rnd_wait t=%0d c=%0d src=%0d: got %h expected %h", t, c, s, obs, {4'b1000, 4'd0, last_wr});
                end
                wb_req = 1'($urandom); wb_src = 4'($urandom); wb_dst = 2'($urandom);
                rt = 5'($urandom); rd = 5'($urandom);
                if (hilo) begin
                    md_busy = !(drop && c == lat - 1);
                    md_done = !drop && (c == lat - 1);
                end else begin
                    md_busy = 1'($urandom); md_done = 1'($urandom);
                end
                tick();
            end
            wb_req = 1'b0; md_busy = 1'b0; md_done = 1'b0;
            n_checks++;
            if (obs !== exp_fin) begin
                n_fail++; $display("FAIL rnd_final t=%0d src=%0d: got %h expected %h", t, s, obs, exp_fin);
            end
            if (s <= 4'd10) last_wr = idx;
            tick();
            n_checks++;
            if (obs !== {4'b0000, 4'd0, last_wr}) begin
                n_fail++; $display("FAIL rnd_idle t=%0d: got %h expected %h", t, obs, {4'b0000, 4'd0, last_wr});
            end
            $display("txn rnd %0d src=%0d dst=%0d lat=%0d", t, s, d, lat);
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_loadsize();
        test_md_wait();
        test_const_and_zero();
        test_illegal();
        test_back_to_back();
        test_reset_midwait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_ctrl.md
Name: writeback_ctrl

Overview:
Sequences the register-file writeback path of the multicycle CPU. It accepts one writeback request from the main control unit and waits until the selected source is valid: memory load data after a fixed latency, and HI/LO after the mult/div unit finishes. It then drives the writeback-mux selector, the destination register index and the write enable for exactly one cycle. It also rejects illegal source codes and suppresses writes to $0.

Parameters:
MEM_WAIT, 2, cycles between the request and LoadSize data being valid (range 1..15)
SEL_W, 4, width of the writeback-mux selector

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
wb_req  input  1  writeback request; sampled only in IDLE
wb_src  input  SEL_W  source code: 0 ALU, 1 LoadSize, 2 HI, 3 LO, 4 EXT1_32, 5 EXT16_32, 6 SLEFT_16, 7 SHIFT_REG, 8 const 227, 9 A, 10 B
wb_dst  input  2  destination select: 0 rt, 1 rd, 2 $31 (ra), 3 $29 (sp)
rt  input  5  rt field of the current instruction
rd  input  5  rd field of the current instruction
md_busy  input  1  mult/div unit running
md_done  input  1  mult/div completion pulse
memtoreg_sel  output  SEL_W  selector to the writeback mux
write_reg  output  5  destination register index
reg_write  output  1  register-file write enable
wb_busy  output  1  request in progress (any state other than IDLE)
wb_ack  output  1  one-cycle completion pulse
src_err  output  1  one-cycle pulse flagging an illegal wb_src

Behaviour:
- All outputs are registered (Moore). Reset values: memtoreg_sel=0, write_reg=0, reg_write=0, wb_busy=0, wb_ack=0, src_err=0, state=IDLE, wait counter=0.
- States are IDLE, WAIT_MEM, WAIT_MD, WRITE and ERR.
- Capture in IDLE:
  - When wb_req=1, latch wb_src.
  - Resolve and latch the destination index: rt, rd, 31 or 29.
  - rt and rd are not used after the capture cycle.
- Transitions from IDLE with wb_req=1:
  - wb_src>10 -> ERR.
  - wb_src=1 -> WAIT_MEM, with counter loaded to MEM_WAIT-1.
  - wb_src in {2,3} and md_busy=1 -> WAIT_MD.
  - Otherwise -> WRITE.
- WAIT_MEM: decrement the counter each cycle; at counter=0 go to WRITE. The state therefore lasts exactly MEM_WAIT cycles.
- WAIT_MD: leave for WRITE in the first cycle where md_done=1 or md_busy=0. There is no timeout.
- WRITE (one cycle), then IDLE:
  - memtoreg_sel = latched source.
  - write_reg = latched index.
  - reg_write=1 unless the latched index is 0.
  - wb_ack=1.
- ERR (one cycle), then IDLE: src_err=1, wb_ack=1, reg_write=0, memtoreg_sel=0.
- Outside WRITE: memtoreg_sel=0, reg_write=0, and write_reg holds its last value.
- wb_busy=1 in WAIT_MEM, WAIT_MD, WRITE and ERR.
- Latency from wb_req sampled in cycle N:
  - Direct sources: WRITE in cycle N+1.
  - LoadSize: WRITE in cycle N+MEM_WAIT+1.
  - HI/LO: WRITE in the cycle after md_done is seen, or N+1 if md_busy=0 at capture.
  - Illegal source: ERR in cycle N+1.
- Boundary conditions:
  - wb_req while wb_busy=1 is ignored; it is neither queued nor acknowledged.
  - wb_req asserted in the same cycle that WRITE/ERR returns to IDLE is sampled in the next (IDLE) cycle, not the returning cycle.
  - md_done and md_busy are ignored for every source other than HI/LO.
  - reset in any state, including WAIT_MEM/WAIT_MD, returns to IDLE next cycle with reset values and produces no write and no ack.
  - reset takes priority over wb_req in the same cycle.

Test Plan:
- Reset, then wb_req with wb_src=0, wb_dst=1, rd=5 -> next cycle: reg_write=1, memtoreg_sel=0, write_reg=5, wb_ack=1; back in IDLE one cycle later.
- MEM_WAIT=2, wb_src=1, wb_dst=0, rt=9 -> wb_busy for 2 WAIT_MEM cycles, then WRITE: sel=1, write_reg=9, reg_write=1, 3 cycles after the request.
- wb_src=2 with md_busy=1, md_done pulsed 20 cycles later -> WAIT_MD for 20 cycles, then WRITE with sel=2; a wb_req during the wait is ignored (exactly one ack).
- wb_src=8, wb_dst=2 -> write_reg=31, sel=8, reg_write=1. wb_dst=0 with rt=0 -> wb_ack=1 but reg_write=0.
- wb_src=12 -> ERR: src_err=1, wb_ack=1, reg_write=0, then IDLE.
- reset asserted during the second WAIT_MEM cycle -> next cycle IDLE, all outputs 0; reg_write is never asserted for that request.
